// File: rtl/tti_timing_gen_if.sv
// TTI timing generator control/status bundle: sync and config inputs,
// tick/info/interrupt outputs.
interface tti_timing_gen_if #(
  parameter int unsigned CNT_W = 16
);
  logic             Enable;
  logic             SyncReq;
  logic [9:0]       SyncSfn;
  logic [3:0]       SyncSf;
  logic [CNT_W-1:0] DemodTimerOffset;
  logic [9:0]       PseudoDciMask;
  logic             IntAck;
  logic             TtiTick;
  logic [13:0]      TtiInfo;
  logic             DemodTimerInt;
  logic             SpPseudoDciInt;
  logic             SyncIntDsp;
  logic             SyncErr;

  modport master (
    output Enable, SyncReq, SyncSfn, SyncSf, DemodTimerOffset, PseudoDciMask, IntAck,
    input  TtiTick, TtiInfo, DemodTimerInt, SpPseudoDciInt, SyncIntDsp, SyncErr
  );

  modport slave (
    input  Enable, SyncReq, SyncSfn, SyncSf, DemodTimerOffset, PseudoDciMask, IntAck,
    output TtiTick, TtiInfo, DemodTimerInt, SpPseudoDciInt, SyncIntDsp, SyncErr
  );
endinterface

// File: rtl/tti_timing_gen.sv
// TTI timing generator: aligns to a sync request, then emits a TTI tick per
// TTI_PERIOD cycles with SFN/subframe tracking, demod timer and pseudo-DCI interrupts.
module tti_timing_gen #(
  parameter int unsigned TTI_PERIOD = 30720,
  parameter int unsigned CNT_W      = 16
) (
  input logic               SystemClock,
  input logic               nReset,
  tti_timing_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } stateT;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TTI_PERIOD - 1);

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [9:0]       sfn, sfnNext;
  logic [3:0]       sf, sfNext;
  logic             tick, tickNext;
  logic             dci, dciNext;
  logic             syncInt, syncIntNext;
  logic             syncErr, syncErrNext;
  logic             demodInt, demodIntNext;
  logic             syncSeen, syncOk, running, wrap, fire;

  always_ff @(posedge SystemClock) begin
    if (!nReset) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    cntNext      = '0;
    sfnNext      = sfn;
    sfNext       = sf;
    tickNext     = 1'b0;
    dciNext      = 1'b0;
    syncIntNext  = 1'b0;
    syncErrNext  = 1'b0;
    demodIntNext = demodInt;

    syncSeen = bus.Enable && bus.SyncReq && (state != IDLE);
    syncOk   = syncSeen && (bus.SyncSf <= 4'd9);
    running  = (state == RUN) && bus.Enable;
    wrap     = running && (cnt == LAST_CNT);
    // cnt never reaches an offset >= TTI_PERIOD, so such offsets never fire
    fire     = (state == RUN) && (cnt == bus.DemodTimerOffset);

    case (state)
      IDLE:    stateNext = ARMED;
      ARMED:   if (syncOk) stateNext = RUN;
      RUN:     stateNext = RUN;
      default: stateNext = IDLE;
    endcase
    if (!bus.Enable) stateNext = IDLE;

    // An accepted sync takes precedence over a coincident wrap: one tick only
    if (syncOk) begin
      sfnNext  = bus.SyncSfn;
      sfNext   = bus.SyncSf;
      tickNext = 1'b1;
    end else if (running) begin
      cntNext = wrap ? '0 : cnt + CNT_W'(1);
      if (wrap) begin
        tickNext = 1'b1;
        if (sf == 4'd9) begin
          sfNext  = 4'd0;
          sfnNext = sfn + 10'd1;
        end else begin
          sfNext  = sf + 4'd1;
        end
      end
    end

    dciNext     = tickNext && bus.PseudoDciMask[sfNext];
    syncIntNext = syncOk;
    syncErrNext = syncSeen && !syncOk;

    if (fire)            demodIntNext = 1'b1;
    else if (bus.IntAck) demodIntNext = 1'b0;
  end

  always_ff @(posedge SystemClock) begin
    if (!nReset) begin
      cnt      <= '0;
      sfn      <= '0;
      sf       <= '0;
      tick     <= 1'b0;
      dci      <= 1'b0;
      syncInt  <= 1'b0;
      syncErr  <= 1'b0;
      demodInt <= 1'b0;
    end else begin
      cnt      <= cntNext;
      sfn      <= sfnNext;
      sf       <= sfNext;
      tick     <= tickNext;
      dci      <= dciNext;
      syncInt  <= syncIntNext;
      syncErr  <= syncErrNext;
      demodInt <= demodIntNext;
    end
  end

  assign bus.TtiTick        = tick;
  assign bus.TtiInfo        = {sfn, sf};
  assign bus.DemodTimerInt  = demodInt;
  assign bus.SpPseudoDciInt = dci;
  assign bus.SyncIntDsp     = syncInt;
  assign bus.SyncErr        = syncErr;

endmodule

// File: tb/tb_tti_timing_gen.sv
// Bench for tti_timing_gen (TTI_PERIOD=20): directed scenarios followed by
// random stimulus, all checked against a frame-index reference model.
module tb_tti_timing_gen;

  localparam int P = 20;

  logic SystemClock = 1'b0;
  logic nReset      = 1'b0;

  tti_timing_gen_if #(.CNT_W(16)) bus ();

  tti_timing_gen #(.TTI_PERIOD(P), .CNT_W(16)) dut (
    .SystemClock (SystemClock),
    .nReset      (nReset),
    .bus         (bus)
  );

  always #5 SystemClock = ~SystemClock;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=idle 1=armed 2=run; mIdx = SFN*10+subframe
  int mMode  = 0;
  int mSince = 0;
  int mIdx   = 0;
  bit eTick, eDemod, eDci, eSyncInt, eErr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelUpdate();
    bit accept, reject, fire, en;
    en = bus.Enable;
    if (!nReset) begin
      mMode = 0; mSince = 0; mIdx = 0;
      eTick = 0; eDemod = 0; eDci = 0; eSyncInt = 0; eErr = 0;
      return;
    end
    accept = (mMode != 0) && en && bus.SyncReq && (bus.SyncSf <= 9);
    reject = (mMode != 0) && en && bus.SyncReq && (bus.SyncSf > 9);
    fire   = (mMode == 2) && ((mSince % P) == int'(bus.DemodTimerOffset));
    eTick = 0; eSyncInt = accept; eErr = reject;
    if (accept) begin
      mIdx   = int'(bus.SyncSfn) * 10 + int'(bus.SyncSf);
      mSince = 0;
      eTick  = 1;
    end else if (mMode == 2 && en) begin
      mSince++;
      if (mSince % P == 0) begin
        mIdx  = (mIdx + 1) % 10240;
        eTick = 1;
      end
    end
    if (!en) begin
      mMode = 0; mSince = 0;
    end else if (mMode == 0) mMode = 1;
    else if (accept) mMode = 2;
    eDci = eTick && bus.PseudoDciMask[mIdx % 10];
    if (fire) eDemod = 1;
    else if (bus.IntAck) eDemod = 0;
  endtask

  function automatic logic [13:0] expInfo();
    logic [9:0] s;
    logic [3:0] f;
    s = 10'(mIdx / 10);
    f = 4'(mIdx % 10);
    return {s, f};
  endfunction

  task automatic step();
    @(posedge SystemClock);
    modelUpdate();
    #1;
    chk("TtiTick",        {15'd0, bus.TtiTick},        {15'd0, eTick});
    chk("TtiInfo",        {2'd0, bus.TtiInfo},         {2'd0, expInfo()});
    chk("DemodTimerInt",  {15'd0, bus.DemodTimerInt},  {15'd0, eDemod});
    chk("SpPseudoDciInt", {15'd0, bus.SpPseudoDciInt}, {15'd0, eDci});
    chk("SyncIntDsp",     {15'd0, bus.SyncIntDsp},     {15'd0, eSyncInt});
    chk("SyncErr",        {15'd0, bus.SyncErr},        {15'd0, eErr});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sync(input logic [9:0] sfn, input logic [3:0] sf);
    bus.SyncReq = 1'b1; bus.SyncSfn = sfn; bus.SyncSf = sf;
    step();
    bus.SyncReq = 1'b0;
  endtask

  initial begin
    int tickCount;
    bus.Enable = 1'b0; bus.SyncReq = 1'b0; bus.SyncSfn = '0; bus.SyncSf = '0;
    bus.DemodTimerOffset = 16'd7; bus.PseudoDciMask = 10'h010; bus.IntAck = 1'b0;

    // Reset state
    run(2);
    chk("rst_info", {2'd0, bus.TtiInfo}, 16'h0000);
    nReset = 1'b1;
    bus.Enable = 1'b1;
    run(3);

    // Sync to SFN 5 / SF 3, then two TTIs
    sync(10'd5, 4'd3);
    chk("sync_tick", {15'd0, bus.TtiTick}, 16'd1);
    chk("sync_dsp",  {15'd0, bus.SyncIntDsp}, 16'd1);
    chk("sync_info", {2'd0, bus.TtiInfo}, 16'h0053);
    chk("sync_dci",  {15'd0, bus.SpPseudoDciInt}, 16'd0);
    run(7);
    chk("demod_pre", {15'd0, bus.DemodTimerInt}, 16'd0);
    step();
    chk("demod_rise", {15'd0, bus.DemodTimerInt}, 16'd1);
    bus.IntAck = 1'b1; step(); bus.IntAck = 1'b0;
    chk("demod_ack", {15'd0, bus.DemodTimerInt}, 16'd0);
    run(11);
    chk("tti1_tick", {15'd0, bus.TtiTick}, 16'd1);
    chk("tti1_info", {2'd0, bus.TtiInfo}, 16'h0054);
    chk("tti1_dci",  {15'd0, bus.SpPseudoDciInt}, 16'd1);
    run(7);
    bus.IntAck = 1'b1; step(); bus.IntAck = 1'b0;
    chk("demod_set_wins", {15'd0, bus.DemodTimerInt}, 16'd1);
    run(12);
    chk("tti2_tick", {15'd0, bus.TtiTick}, 16'd1);
    chk("tti2_info", {2'd0, bus.TtiInfo}, 16'h0055);
    chk("tti2_dci",  {15'd0, bus.SpPseudoDciInt}, 16'd0);

    // Rejected sync in RUN
    run(3);
    sync(10'd100, 4'd12);
    chk("rej_err",  {15'd0, bus.SyncErr}, 16'd1);
    chk("rej_tick", {15'd0, bus.TtiTick}, 16'd0);
    chk("rej_info", {2'd0, bus.TtiInfo}, 16'h0055);
    step();
    chk("rej_err_end", {15'd0, bus.SyncErr}, 16'd0);
    run(15);
    chk("rej_cadence", {15'd0, bus.TtiTick}, 16'd1);
    chk("rej_info2",   {2'd0, bus.TtiInfo}, 16'h0056);

    // Sync coinciding with a wrap, SFN 1023 / SF 9 rolls over to 0
    run(19);
    sync(10'd1023, 4'd9);
    chk("wrap_sync_info", {2'd0, bus.TtiInfo}, 16'h3FF9);
    step();
    chk("no_double_tick", {15'd0, bus.TtiTick}, 16'd0);
    run(19);
    chk("sfn_wrap_tick", {15'd0, bus.TtiTick}, 16'd1);
    chk("sfn_wrap_info", {2'd0, bus.TtiInfo}, 16'h0000);

    // Reset mid-TTI with a pending interrupt
    run(10);
    chk("pre_rst_int", {15'd0, bus.DemodTimerInt}, 16'd1);
    nReset = 1'b0; step(); nReset = 1'b1;
    chk("rst_int",  {15'd0, bus.DemodTimerInt}, 16'd0);
    chk("rst_info2", {2'd0, bus.TtiInfo}, 16'h0000);
    tickCount = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.TtiTick === 1'b1) tickCount++;
    end
    chk("no_tick_after_rst", 16'(tickCount), 16'd0);

    // Enable drop in RUN: info held, no ticks
    sync(10'd17, 4'd2);
    run(5);
    bus.Enable = 1'b0; step(); bus.Enable = 1'b1;
    run(25);
    chk("idle_info_hold", {2'd0, bus.TtiInfo}, 16'h0112);

    // Randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      nReset     = ($urandom_range(199) != 0);
      bus.Enable = ($urandom_range(59) != 0);
      bus.SyncReq = ($urandom_range(24) == 0);
      bus.SyncSfn = 10'($urandom_range(1023));
      bus.SyncSf  = 4'($urandom_range(15));
      bus.IntAck  = ($urandom_range(9) == 0);
      if ($urandom_range(49) == 0) bus.DemodTimerOffset = 16'($urandom_range(24));
      if ($urandom_range(29) == 0) bus.PseudoDciMask = 10'($urandom_range(1023));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
